// File: rtl/fg_pkg.sv
// Shared types and widths for the function-generator phase/config controller.
package fg_pkg;

    localparam int unsigned PW     = 8;
    localparam int unsigned DIVW   = 8;
    localparam int unsigned BURSTW = 8;

    localparam logic [PW-1:0] PHASE_MAX = '1;

    typedef enum logic [1:0] {
        SQUARE   = 2'd0,
        TRIANGLE = 2'd1,
        SAW      = 2'd2,
        SINE     = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } seq_state_t;

    typedef struct packed {
        wave_t           wave;
        logic [DIVW-1:0] div;
    } cfg_t;

endpackage

// File: rtl/wave_sequencer_if.sv
// Control/config/phase bundle between the host side and wave_sequencer.
// WAVE_BURST_EN adds burst_len/done.
interface wave_sequencer_if;
    import fg_pkg::*;

    logic            start;
    logic            stop;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_wave;
    logic [DIVW-1:0] cfg_div;
    logic [PW-1:0]   count_clk;
    logic [1:0]      wave_sel;
    logic            running;
    logic            wrap;
`ifdef WAVE_BURST_EN
    logic [BURSTW-1:0] burst_len;
    logic              done;

    modport master (output start, stop, cfg_valid, cfg_wave, cfg_div, burst_len,
                    input  cfg_ready, count_clk, wave_sel, running, wrap, done);
    modport slave  (input  start, stop, cfg_valid, cfg_wave, cfg_div, burst_len,
                    output cfg_ready, count_clk, wave_sel, running, wrap, done);
`else
    modport master (output start, stop, cfg_valid, cfg_wave, cfg_div,
                    input  cfg_ready, count_clk, wave_sel, running, wrap);
    modport slave  (input  start, stop, cfg_valid, cfg_wave, cfg_div,
                    output cfg_ready, count_clk, wave_sel, running, wrap);
`endif

endinterface

// File: rtl/fg_prescaler.sv
// Clock prescaler: tick_c fires once every div+1 enabled clocks.
module fg_prescaler
    import fg_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic [DIVW-1:0] div,
    output logic            tick_c
);

    logic [DIVW-1:0] presc;

    assign tick_c = en && (presc == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clear || !en || tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + DIVW'(1);
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Phase counter, waveform/prescaler config staging and run control for the function generator.
// Optional WAVE_BURST_EN: stop automatically after burst_len phase wraps and pulse done.
module wave_sequencer
    import fg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    wave_sequencer_if.slave  bus
);

    seq_state_t      state, state_d;
    logic [PW-1:0]   count_q, count_d;
    wave_t           wave_q, wave_d;
    logic [DIVW-1:0] div_q, div_d;
    cfg_t            stg_q, stg_d;
    logic            running_q, ready_q, wrap_q;
    logic            tick_c, clear_c, last_c, xfer_c;
    cfg_t            cfg_in_c;
`ifdef WAVE_BURST_EN
    logic [BURSTW-1:0] burst_q, burst_d, wraps_q, wraps_d;
    logic              done_q, done_d;
`endif

    fg_prescaler u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (running_q),
        .clear  (clear_c),
        .div    (div_q),
        .tick_c (tick_c)
    );

    assign last_c   = tick_c && (count_q == PHASE_MAX);
    assign xfer_c   = bus.cfg_valid && ready_q;
    assign cfg_in_c = '{wave: wave_t'(bus.cfg_wave), div: bus.cfg_div};

    // Next-state, phase and config commit logic
    always_comb begin
        state_d = state;
        count_d = count_q;
        wave_d  = wave_q;
        div_d   = div_q;
        stg_d   = stg_q;
        clear_c = 1'b0;
`ifdef WAVE_BURST_EN
        burst_d = burst_q;
        wraps_d = wraps_q;
        done_d  = 1'b0;
`endif
        if (tick_c) count_d = count_q + PW'(1);

        case (state)
            IDLE: begin
                if (xfer_c) begin
                    wave_d = cfg_in_c.wave;
                    div_d  = cfg_in_c.div;
                end
                if (bus.start && !bus.stop) begin
                    state_d = RUN;
`ifdef WAVE_BURST_EN
                    burst_d = bus.burst_len;
                    wraps_d = '0;
`endif
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    clear_c = 1'b1;
                end else if (xfer_c) begin
                    stg_d   = cfg_in_c;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.stop || last_c) begin
                    wave_d  = stg_q.wave;
                    div_d   = stg_q.div;
                    clear_c = 1'b1;
                    state_d = bus.stop ? IDLE : RUN;
                    if (bus.stop) count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef WAVE_BURST_EN
        // Final wrap of a finite burst ends the run; a config offered on that edge commits directly
        if (state != IDLE && !bus.stop && last_c && burst_q != '0) begin
            if (wraps_q + BURSTW'(1) == burst_q) begin
                if (state == RUN && xfer_c) begin
                    wave_d = cfg_in_c.wave;
                    div_d  = cfg_in_c.div;
                end
                state_d = IDLE;
                count_d = '0;
                clear_c = 1'b1;
                done_d  = 1'b1;
            end else begin
                wraps_d = wraps_q + BURSTW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_q   <= '0;
            wave_q    <= SQUARE;
            div_q     <= '0;
            stg_q     <= '{wave: SQUARE, div: '0};
            running_q <= 1'b0;
            ready_q   <= 1'b1;
            wrap_q    <= 1'b0;
        end else begin
            state     <= state_d;
            count_q   <= count_d;
            wave_q    <= wave_d;
            div_q     <= div_d;
            stg_q     <= stg_d;
            running_q <= (state_d != IDLE);
            ready_q   <= (state_d != PEND);
            wrap_q    <= last_c;
        end
    end

`ifdef WAVE_BURST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
            wraps_q <= '0;
            done_q  <= 1'b0;
        end else begin
            burst_q <= burst_d;
            wraps_q <= wraps_d;
            done_q  <= done_d;
        end
    end

    assign bus.done = done_q;
`endif

    assign bus.count_clk = count_q;
    assign bus.wave_sel  = wave_q;
    assign bus.running   = running_q;
    assign bus.cfg_ready = ready_q;
    assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed bench for wave_sequencer: per-cycle vector table plus multi-cycle timing sequences.
module tb_wave_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   miscmp  = 0;

    always #5 clk = ~clk;

    wave_sequencer_if bus();

    wave_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int st, sp, cv, w, d;
        int ec, ew, er, erd, ewr;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input int w, input int d);
        bus.cfg_valid = 1'b1;
        bus.cfg_wave  = 2'(w);
        bus.cfg_div   = 8'(d);
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic wait_count(input int v, input int bound, input string name);
        int n = 0;
        while (int'(bus.count_clk) != v && n < bound) begin
            step();
            n++;
        end
        chk(name, int'(bus.count_clk), v);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, second, prev, early, dones;

        // start, stop, cfg_valid, wave, div  ->  count, wave_sel, running, cfg_ready, wrap
        vt[0]  = '{0,0,0,0,0,  0,0,0,1,0};
        vt[1]  = '{0,0,1,3,1,  0,3,0,1,0};
        vt[2]  = '{1,0,0,0,0,  0,3,1,1,0};
        vt[3]  = '{0,0,0,0,0,  0,3,1,1,0};
        vt[4]  = '{0,0,0,0,0,  1,3,1,1,0};
        vt[5]  = '{0,0,0,0,0,  1,3,1,1,0};
        vt[6]  = '{0,0,0,0,0,  2,3,1,1,0};
        vt[7]  = '{1,0,0,0,0,  2,3,1,1,0};
        vt[8]  = '{0,0,1,2,0,  3,3,1,0,0};
        vt[9]  = '{0,0,1,1,0,  3,3,1,0,0};
        vt[10] = '{0,1,0,0,0,  0,2,0,1,0};
        vt[11] = '{0,0,0,0,0,  0,2,0,1,0};
        vt[12] = '{1,1,0,0,0,  0,2,0,1,0};
        vt[13] = '{1,0,0,0,0,  0,2,1,1,0};
        vt[14] = '{0,0,0,0,0,  1,2,1,1,0};
        vt[15] = '{0,0,0,0,0,  2,2,1,1,0};
        vt[16] = '{1,1,0,0,0,  0,2,0,1,0};
        vt[17] = '{0,0,0,0,0,  0,2,0,1,0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_wave  = 2'd0;
        bus.cfg_div   = 8'd0;
`ifdef WAVE_BURST_EN
        bus.burst_len = 8'd0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset count", int'(bus.count_clk), 0);
        chk("reset wave_sel", int'(bus.wave_sel), 0);
        chk("reset running", int'(bus.running), 0);
        chk("reset cfg_ready", int'(bus.cfg_ready), 1);
        chk("reset wrap", int'(bus.wrap), 0);

        for (int i = 0; i < 18; i++) begin
            bus.start     = 1'(vt[i].st);
            bus.stop      = 1'(vt[i].sp);
            bus.cfg_valid = 1'(vt[i].cv);
            bus.cfg_wave  = 2'(vt[i].w);
            bus.cfg_div   = 8'(vt[i].d);
            step();
            chk($sformatf("vec%0d count", i), int'(bus.count_clk), vt[i].ec);
            chk($sformatf("vec%0d wave_sel", i), int'(bus.wave_sel), vt[i].ew);
            chk($sformatf("vec%0d running", i), int'(bus.running), vt[i].er);
            chk($sformatf("vec%0d cfg_ready", i), int'(bus.cfg_ready), vt[i].erd);
            chk($sformatf("vec%0d wrap", i), int'(bus.wrap), vt[i].ewr);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cfg_valid = 1'b0;

        // Asynchronous reset while running at phase 0x5A
        send_cfg(3, 0);
        pulse_start();
        wait_count(8'h5A, 300, "t1 reach 0x5A");
        #2 rst = 1'b1;
        #1;
        chk("t1 async count", int'(bus.count_clk), 0);
        chk("t1 async running", int'(bus.running), 0);
        chk("t1 async cfg_ready", int'(bus.cfg_ready), 1);
        chk("t1 async wave_sel", int'(bus.wave_sel), 0);
        step();
        rst = 1'b0;

        // IDLE commit wave=2 div=3, phase steps every 4 clocks, first wrap after 1024
        send_cfg(2, 3);
        chk("t2 idle commit wave", int'(bus.wave_sel), 2);
        pulse_start();
        n = 0; first = -1; second = -1; prev = int'(bus.count_clk);
        while (!bus.wrap && n < 1100) begin
            step();
            n++;
            if (int'(bus.count_clk) != prev) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
                prev = int'(bus.count_clk);
            end
        end
        chk("t2 first step", first, 4);
        chk("t2 second step", second, 8);
        chk("t2 wrap clocks", n, 1024);
        chk("t2 count at wrap", int'(bus.count_clk), 0);

        // Config offered mid-run is held until the phase wrap
        wait_count(8'h40, 400, "t3 reach 0x40");
        send_cfg(1, 0);
        chk("t3 cfg_ready low", int'(bus.cfg_ready), 0);
        chk("t3 wave_sel held", int'(bus.wave_sel), 2);
        n = 0; early = 0;
        while (!bus.wrap && n < 1200) begin
            step();
            n++;
            if (!bus.wrap && bus.wave_sel != 2'd2) early = 1;
        end
        chk("t3 no early commit", early, 0);
        chk("t3 wave_sel at wrap", int'(bus.wave_sel), 1);
        chk("t3 count at wrap", int'(bus.count_clk), 0);
        chk("t3 cfg_ready after commit", int'(bus.cfg_ready), 1);
        step();
        chk("t3 step div0 a", int'(bus.count_clk), 1);
        step();
        chk("t3 step div0 b", int'(bus.count_clk), 2);

        // start and stop together while running: stop wins
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("t4 running", int'(bus.running), 0);
        chk("t4 count", int'(bus.count_clk), 0);
        repeat (5) step();
        chk("t4 no ticks", int'(bus.count_clk), 0);

        // Maximum divide: 256 clocks per step, 65536 per period
        send_cfg(0, 255);
        pulse_start();
        n = 0; first = -1; second = -1; prev = int'(bus.count_clk);
        while (!bus.wrap && n < 66000) begin
            step();
            n++;
            if (int'(bus.count_clk) != prev) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
                prev = int'(bus.count_clk);
            end
        end
        chk("t5 first step", first, 256);
        chk("t5 second step", second, 512);
        chk("t5 wrap clocks", n, 65536);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t5 stopped", int'(bus.running), 0);

`ifdef WAVE_BURST_EN
        // Two-wrap burst ends by itself with one done pulse
        send_cfg(0, 0);
        bus.burst_len = 8'd2;
        pulse_start();
        n = 0;
        while (!bus.done && n < 700) begin
            step();
            n++;
        end
        chk("t6 done clocks", n, 512);
        chk("t6 running at done", int'(bus.running), 0);
        chk("t6 count at done", int'(bus.count_clk), 0);
        dones = 0;
        repeat (600) begin
            step();
            if (bus.done || bus.wrap) dones++;
        end
        chk("t6 idle after burst", dones, 0);
        chk("t6 idle count", int'(bus.count_clk), 0);

        // stop during a burst aborts without done
        pulse_start();
        dones = 0;
        repeat (299) begin
            step();
            if (bus.done) dones++;
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        repeat (600) begin
            step();
            if (bus.done) dones++;
        end
        chk("t6 abort no done", dones, 0);
        chk("t6 abort count", int'(bus.count_clk), 0);
        chk("t6 abort running", int'(bus.running), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
